// File: rtl/data_sram_if.sv
// SRAM-like data request bus: request fields with addr_ok accept, in-order data_ok/rdata responses.
// master = requester (execute stage or bench), slave = memory-side responder.
interface data_sram_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_size, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_size, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Data-side memory model: in-order responses LATENCY cycles after accept, up to OUTSTANDING in flight.
// addr_ok drops on addr_stall or a full queue (no same-cycle bypass); data_stall holds the head response.
module data_sram_responder #(
  parameter int DEPTH_W     = 10,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         reset,
  data_sram_if.slave   bus,
  input  logic         addr_stall,
  input  logic         data_stall
);
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(LATENCY - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(OUTSTANDING);

  logic [31:0]            mem [2**DEPTH_W];
  logic [OUTSTANDING-1:0] ent_vld;
  logic                   ent_wr  [OUTSTANDING];
  logic [31:0]            ent_dat [OUTSTANDING];
  logic [LAT_W-1:0]       ent_cnt [OUTSTANDING];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;

  logic [DEPTH_W-1:0] idx;
  logic               is_read;
  logic               accept;
  logic               pop;
  logic               unused_bits;

  // High address bits and the byte offset are dropped, so addresses alias every 2**DEPTH_W words.
  assign idx         = bus.data_sram_addr[DEPTH_W+1:2];
  assign is_read     = (bus.data_sram_wen == 4'b0000);
  assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[31:DEPTH_W+2], bus.data_sram_addr[1:0]};

  assign bus.data_sram_addr_ok = !addr_stall && (count != CNT_FULL);
  assign accept = bus.data_sram_en && bus.data_sram_addr_ok;
  assign pop    = ent_vld[rd_ptr] && (ent_cnt[rd_ptr] == '0) && !data_stall;

  assign bus.data_sram_data_ok = pop;
  assign bus.data_sram_rdata   = (pop && !ent_wr[rd_ptr]) ? ent_dat[rd_ptr] : 32'h0;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Memory contents survive reset; only requests accepted outside reset touch it.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_sram_wen[b]) mem[idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_vld <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        ent_wr[i]  <= 1'b0;
        ent_dat[i] <= 32'h0;
        ent_cnt[i] <= '0;
      end
    end else begin
      // Every queued entry ages in parallel so stalled followers are ready the moment the head leaves.
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (ent_vld[i] && ent_cnt[i] != '0) ent_cnt[i] <= ent_cnt[i] - 1'b1;
      end
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_next(rd_ptr);
      end
      if (accept) begin
        ent_vld[wr_ptr] <= 1'b1;
        ent_cnt[wr_ptr] <= LAT_INIT;
        ent_wr[wr_ptr]  <= !is_read;
        ent_dat[wr_ptr] <= is_read ? mem[idx] : 32'h0;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: default-parameter instance plus a LATENCY=1 instance.
module tb_data_sram_responder;
  logic clk = 1'b0;
  logic reset;
  logic addr_stall, data_stall;
  logic b_addr_stall, b_data_stall;
  logic as_q, ds_q;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  data_sram_if bus_a ();
  data_sram_if bus_b ();

  data_sram_responder #(.DEPTH_W(10), .LATENCY(2), .OUTSTANDING(4)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_a.slave),
    .addr_stall (addr_stall),
    .data_stall (data_stall)
  );

  data_sram_responder #(.DEPTH_W(10), .LATENCY(1), .OUTSTANDING(4)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_b.slave),
    .addr_stall (b_addr_stall),
    .data_stall (b_data_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive one cycle on bus A at the falling edge; outputs are then sampled 1 ns later.
  task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus_a.data_sram_en    = en;
    bus_a.data_sram_wen   = wen;
    bus_a.data_sram_addr  = addr;
    bus_a.data_sram_size  = 2'd2;
    bus_a.data_sram_wdata = wdata;
    addr_stall = as_q;
    data_stall = ds_q;
    #1;
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b1, 4'b0000, addr, 32'h0);
  endtask

  task automatic wr(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    step(1'b1, wen, addr, wdata);
  endtask

  task automatic idle();
    step(1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  task automatic step_b(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus_b.data_sram_en    = en;
    bus_b.data_sram_wen   = wen;
    bus_b.data_sram_addr  = addr;
    bus_b.data_sram_size  = 2'd2;
    bus_b.data_sram_wdata = wdata;
    #1;
  endtask

  // Consume the next response on bus A within a bounded number of cycles.
  task automatic wait_resp(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 16; i++) begin
      if (bus_a.data_sram_data_ok) break;
      idle();
    end
    check({tag, " data_ok"}, 32'(bus_a.data_sram_data_ok), 1);
    check({tag, " rdata"}, bus_a.data_sram_rdata, exp);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    as_q = 1'b0;
    ds_q = 1'b0;
    addr_stall = 1'b0;
    data_stall = 1'b0;
    b_addr_stall = 1'b0;
    b_data_stall = 1'b0;
    bus_a.data_sram_en = 1'b0;   bus_a.data_sram_wen = 4'h0;  bus_a.data_sram_addr = 32'h0;
    bus_a.data_sram_size = 2'd2; bus_a.data_sram_wdata = 32'h0;
    bus_b.data_sram_en = 1'b0;   bus_b.data_sram_wen = 4'h0;  bus_b.data_sram_addr = 32'h0;
    bus_b.data_sram_size = 2'd2; bus_b.data_sram_wdata = 32'h0;

    // Reset values
    idle();
    check("rst data_ok", 32'(bus_a.data_sram_data_ok), 0);
    check("rst rdata", bus_a.data_sram_rdata, 32'h0);
    check("rst addr_ok", 32'(bus_a.data_sram_addr_ok), 1);
    check("rst b data_ok", 32'(bus_b.data_sram_data_ok), 0);
    as_q = 1'b1;
    idle();
    check("rst addr_stall addr_ok", 32'(bus_a.data_sram_addr_ok), 0);
    as_q = 1'b0;
    reset = 1'b0;
    idle();

    // 1: word write then read
    wr(4'hF, 32'h10, 32'h11223344);
    check("s1 c0 addr_ok", 32'(bus_a.data_sram_addr_ok), 1);
    check("s1 c0 data_ok", 32'(bus_a.data_sram_data_ok), 0);
    rd(32'h10);
    check("s1 c1 data_ok", 32'(bus_a.data_sram_data_ok), 0);
    idle();
    check("s1 c2 data_ok", 32'(bus_a.data_sram_data_ok), 1);
    check("s1 c2 rdata", bus_a.data_sram_rdata, 32'h0);
    idle();
    check("s1 c3 data_ok", 32'(bus_a.data_sram_data_ok), 1);
    check("s1 c3 rdata", bus_a.data_sram_rdata, 32'h11223344);
    idle();
    check("s1 c4 data_ok", 32'(bus_a.data_sram_data_ok), 0);

    // 2: byte merge
    wr(4'b0010, 32'h10, 32'hAAAAAAAA);
    rd(32'h10);
    wait_resp("s2 wr", 32'h0);
    wait_resp("s2 rd", 32'h1122AA44);

    // 3: pipelined reads
    for (int k = 0; k < 4; k++) wr(4'hF, 32'(4 * k), 32'(k + 1));
    repeat (6) idle();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) rd(32'(4 * k));
      else idle();
      check($sformatf("s3 c%0d addr_ok", k), 32'(bus_a.data_sram_addr_ok), 1);
      if (k >= 2) begin
        check($sformatf("s3 c%0d data_ok", k), 32'(bus_a.data_sram_data_ok), 1);
        check($sformatf("s3 c%0d rdata", k), bus_a.data_sram_rdata, 32'(k - 1));
      end else begin
        check($sformatf("s3 c%0d data_ok", k), 32'(bus_a.data_sram_data_ok), 0);
      end
    end
    idle();

    // 4: full queue under data_stall
    ds_q = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd(32'(4 * k));
      check($sformatf("s4 acc%0d addr_ok", k), 32'(bus_a.data_sram_addr_ok), 1);
    end
    rd(32'h10);
    check("s4 full addr_ok", 32'(bus_a.data_sram_addr_ok), 0);
    check("s4 stalled data_ok", 32'(bus_a.data_sram_data_ok), 0);
    rd(32'h10);
    check("s4 full hold addr_ok", 32'(bus_a.data_sram_addr_ok), 0);
    ds_q = 1'b0;
    rd(32'h10);
    check("s4 pop1 addr_ok nobypass", 32'(bus_a.data_sram_addr_ok), 0);
    check("s4 pop1 data_ok", 32'(bus_a.data_sram_data_ok), 1);
    check("s4 pop1 rdata", bus_a.data_sram_rdata, 32'd1);
    rd(32'h10);
    check("s4 fifth addr_ok", 32'(bus_a.data_sram_addr_ok), 1);
    check("s4 pop2 data_ok", 32'(bus_a.data_sram_data_ok), 1);
    check("s4 pop2 rdata", bus_a.data_sram_rdata, 32'd2);
    idle();
    check("s4 pop3 data_ok", 32'(bus_a.data_sram_data_ok), 1);
    check("s4 pop3 rdata", bus_a.data_sram_rdata, 32'd3);
    idle();
    check("s4 pop4 data_ok", 32'(bus_a.data_sram_data_ok), 1);
    check("s4 pop4 rdata", bus_a.data_sram_rdata, 32'd4);
    idle();
    check("s4 pop5 data_ok", 32'(bus_a.data_sram_data_ok), 1);
    check("s4 pop5 rdata", bus_a.data_sram_rdata, 32'h1122AA44);
    idle();
    check("s4 empty data_ok", 32'(bus_a.data_sram_data_ok), 0);

    // 5: reset with two reads outstanding
    rd(32'h10);
    rd(32'h0);
    idle();
    check("s5 pre data_ok", 32'(bus_a.data_sram_data_ok), 1);
    check("s5 pre rdata", bus_a.data_sram_rdata, 32'h1122AA44);
    #2 reset = 1'b1;
    #1;
    check("s5 rst data_ok", 32'(bus_a.data_sram_data_ok), 0);
    check("s5 rst rdata", bus_a.data_sram_rdata, 32'h0);
    check("s5 rst addr_ok", 32'(bus_a.data_sram_addr_ok), 1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle();
      check($sformatf("s5 post%0d data_ok", k), 32'(bus_a.data_sram_data_ok), 0);
      check($sformatf("s5 post%0d addr_ok", k), 32'(bus_a.data_sram_addr_ok), 1);
    end
    rd(32'h10);
    wait_resp("s5 mem kept", 32'h1122AA44);

    // 6: aliasing with LATENCY=1
    step_b(1'b1, 4'hF, 32'h00001010, 32'hDEADBEEF);
    check("s6 wr addr_ok", 32'(bus_b.data_sram_addr_ok), 1);
    check("s6 wr data_ok early", 32'(bus_b.data_sram_data_ok), 0);
    step_b(1'b1, 4'h0, 32'h00000010, 32'h0);
    check("s6 rd addr_ok", 32'(bus_b.data_sram_addr_ok), 1);
    check("s6 wr data_ok", 32'(bus_b.data_sram_data_ok), 1);
    check("s6 wr rdata", bus_b.data_sram_rdata, 32'h0);
    step_b(1'b0, 4'h0, 32'h0, 32'h0);
    check("s6 rd data_ok", 32'(bus_b.data_sram_data_ok), 1);
    check("s6 rd rdata", bus_b.data_sram_rdata, 32'hDEADBEEF);
    step_b(1'b0, 4'h0, 32'h0, 32'h0);
    check("s6 idle data_ok", 32'(bus_b.data_sram_data_ok), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
